// File: rtl/uparc_reg_file_mp.sv
// Multi-port register file: two combinational read ports with write bypass, a pipeline writeback
// port, a late load-return port and an optional pending-load scoreboard (UPARC_RF_SCOREBOARD_EN).
module uparc_reg_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs,
  input  logic [ADDR_WIDTH-1:0] rt,
  output logic [DATA_WIDTH-1:0] rs_data,
  output logic [DATA_WIDTH-1:0] rt_data,
  output logic                  rs_busy,
  output logic                  rt_busy,
  input  logic                  wb_we,
  input  logic [ADDR_WIDTH-1:0] wb_rd,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_rd,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  pend_set,
  input  logic [ADDR_WIDTH-1:0] pend_rd,
  output logic                  pend_any
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] regs_d [DEPTH];

  // Load return is applied first so a colliding writeback overwrites it.
  always_comb begin
    // NOTE: every always_comb output gets a full default first so no latch is inferred.
    regs_d = regs_q;
    if (ld_we) regs_d[ld_rd] = ld_data;
    if (wb_we) regs_d[wb_rd] = wb_data;
    regs_d[0] = '0;
  end

  // NOTE: this storage must clear asynchronously, so unlike a typical RAM it carries a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      regs_q <= regs_d;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] idx);
    if (idx == '0)                   return '0;
    else if (wb_we && wb_rd == idx)  return wb_data;
    else if (ld_we && ld_rd == idx)  return ld_data;
    else                             return regs_q[idx];
  endfunction

  always_comb begin
    rs_data = read_port(rs);
    rt_data = read_port(rt);
  end

`ifdef UPARC_RF_SCOREBOARD_EN
  logic [DEPTH-1:0] pend_q;
  logic [DEPTH-1:0] pend_d;

  // Set follows clear so a new load issued as the old one returns stays pending.
  always_comb begin
    pend_d = pend_q;
    if (ld_we)    pend_d[ld_rd]   = 1'b0;
    if (pend_set) pend_d[pend_rd] = 1'b1;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= '0;
    else     pend_q <= pend_d;
  end

  always_comb begin
    rs_busy  = (rs != '0) && pend_q[rs] && !(ld_we && ld_rd == rs);
    rt_busy  = (rt != '0) && pend_q[rt] && !(ld_we && ld_rd == rt);
    pend_any = |pend_q;
  end
`else
  logic unused_pend;
  assign unused_pend = pend_set ^ (^pend_rd);

  always_comb begin
    rs_busy  = 1'b0;
    rt_busy  = 1'b0;
    pend_any = 1'b0;
  end
`endif

endmodule

// File: tb/tb_uparc_reg_file_mp.sv
// Directed self-checking bench for uparc_reg_file_mp; scoreboard expectations follow
// whether UPARC_RF_SCOREBOARD_EN is defined for the build.
module tb_uparc_reg_file_mp;

`ifdef UPARC_RF_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk, rst;
  logic [4:0]  rs, rt, wb_rd, ld_rd, pend_rd;
  logic [31:0] rs_data, rt_data, wb_data, ld_data;
  logic        rs_busy, rt_busy, wb_we, ld_we, pend_set, pend_any;

  int n_cmp = 0;
  int n_bad = 0;

  uparc_reg_file_mp dut (
    .clk(clk), .rst(rst), .rs(rs), .rt(rt), .rs_data(rs_data), .rt_data(rt_data),
    .rs_busy(rs_busy), .rt_busy(rt_busy), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ld_we(ld_we), .ld_rd(ld_rd), .ld_data(ld_data), .pend_set(pend_set), .pend_rd(pend_rd),
    .pend_any(pend_any)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    wb_we = 0; wb_rd = 0; wb_data = 0;
    ld_we = 0; ld_rd = 0; ld_data = 0;
    pend_set = 0; pend_rd = 0;
  endtask

  // Advance past the next rising edge; inputs then change well away from it.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; rs = 0; rt = 0; idle();
    step(); step();
    rst = 0;
    step();
    for (int i = 0; i < 32; i++) begin
      rs = i[4:0]; rt = 5'(31 - i); #1;
      n_cmp++;
      if (rs_data !== 32'h0 || rt_data !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_data idx=%0d: rs_data=%h rt_data=%h, want 0", i, rs_data, rt_data);
      end
      n_cmp++;
      if (rs_busy !== 1'b0 || rt_busy !== 1'b0 || pend_any !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_busy idx=%0d: rs_busy=%b rt_busy=%b pend_any=%b, want 0", i, rs_busy, rt_busy, pend_any);
      end
    end
  endtask

  task automatic test_wb_bypass();
    wb_we = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; rs = 5; rt = 6; #1;
    n_cmp++;
    if (rs_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wb_bypass: got %h want deadbeef", rs_data); end
    n_cmp++;
    if (rt_data !== 32'h0) begin n_bad++; $display("FAIL wb_bypass_other: got %h want 0", rt_data); end
    step(); idle(); #1;
    n_cmp++;
    if (rs_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL wb_stored: got %h want deadbeef", rs_data); end
    n_cmp++;
    if (rt_data !== 32'h0) begin n_bad++; $display("FAIL wb_stored_other: got %h want 0", rt_data); end
  endtask

  task automatic test_ld_bypass();
    ld_we = 1; ld_rd = 8; ld_data = 32'h33; rt = 8; #1;
    n_cmp++;
    if (rt_data !== 32'h33) begin n_bad++; $display("FAIL ld_bypass: got %h want 33", rt_data); end
    step(); idle(); #1;
    n_cmp++;
    if (rt_data !== 32'h33) begin n_bad++; $display("FAIL ld_stored: got %h want 33", rt_data); end
  endtask

  task automatic test_collision();
    wb_we = 1; wb_rd = 7; wb_data = 32'h11;
    ld_we = 1; ld_rd = 7; ld_data = 32'h22; rs = 7; rt = 7; #1;
    n_cmp++;
    if (rs_data !== 32'h11 || rt_data !== 32'h11) begin
      n_bad++; $display("FAIL collide_bypass: rs=%h rt=%h want 11", rs_data, rt_data);
    end
    step(); idle(); #1;
    n_cmp++;
    if (rs_data !== 32'h11) begin n_bad++; $display("FAIL collide_stored: got %h want 11", rs_data); end
  endtask

  task automatic test_scoreboard();
    pend_set = 1; pend_rd = 9; rt = 9; rs = 9;
    step(); idle(); #1;
    n_cmp++;
    if (rt_busy !== SB || rs_busy !== SB) begin
      n_bad++; $display("FAIL pend_busy: rs_busy=%b rt_busy=%b want %b", rs_busy, rt_busy, SB);
    end
    n_cmp++;
    if (pend_any !== SB) begin n_bad++; $display("FAIL pend_any_set: got %b want %b", pend_any, SB); end
    ld_we = 1; ld_rd = 9; ld_data = 32'h55; #1;
    n_cmp++;
    if (rt_busy !== 1'b0 || rt_data !== 32'h55) begin
      n_bad++; $display("FAIL ld_return: rt_busy=%b rt_data=%h want 0/55", rt_busy, rt_data);
    end
    n_cmp++;
    if (pend_any !== SB) begin n_bad++; $display("FAIL pend_any_nobypass: got %b want %b", pend_any, SB); end
    step(); idle(); #1;
    n_cmp++;
    if (pend_any !== 1'b0 || rt_data !== 32'h55) begin
      n_bad++; $display("FAIL pend_cleared: pend_any=%b rt_data=%h want 0/55", pend_any, rt_data);
    end

    // New load issued on the cycle the old one returns stays pending.
    pend_set = 1; pend_rd = 10; rs = 10;
    step(); idle();
    pend_set = 1; pend_rd = 10; ld_we = 1; ld_rd = 10; ld_data = 32'h66;
    step(); idle(); #1;
    n_cmp++;
    if (rs_busy !== SB || rs_data !== 32'h66) begin
      n_bad++; $display("FAIL set_wins: rs_busy=%b rs_data=%h want %b/66", rs_busy, rs_data, SB);
    end

    // Writeback leaves pending state alone.
    wb_we = 1; wb_rd = 10; wb_data = 32'h77;
    step(); idle(); #1;
    n_cmp++;
    if (rs_busy !== SB || rs_data !== 32'h77) begin
      n_bad++; $display("FAIL wb_keeps_pend: rs_busy=%b rs_data=%h want %b/77", rs_busy, rs_data, SB);
    end
    ld_we = 1; ld_rd = 10; ld_data = 32'h88;
    step(); idle(); #1;
    n_cmp++;
    if (rs_busy !== 1'b0 || pend_any !== 1'b0 || rs_data !== 32'h88) begin
      n_bad++; $display("FAIL pend_drain: rs_busy=%b pend_any=%b rs_data=%h want 0/0/88", rs_busy, pend_any, rs_data);
    end
  endtask

  task automatic test_reg_zero();
    wb_we = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
    ld_we = 1; ld_rd = 0; ld_data = 32'hFFFFFFFF;
    pend_set = 1; pend_rd = 0; rs = 0; rt = 0; #1;
    n_cmp++;
    if (rs_data !== 32'h0 || rs_busy !== 1'b0) begin
      n_bad++; $display("FAIL r0_bypass: rs_data=%h rs_busy=%b want 0/0", rs_data, rs_busy);
    end
    step(); idle(); #1;
    n_cmp++;
    if (rs_data !== 32'h0 || rs_busy !== 1'b0 || pend_any !== 1'b0) begin
      n_bad++; $display("FAIL r0_stored: rs_data=%h rs_busy=%b pend_any=%b want 0", rs_data, rs_busy, pend_any);
    end
  endtask

  task automatic test_async_reset();
    wb_we = 1; wb_rd = 3; wb_data = 32'h1234;
    pend_set = 1; pend_rd = 4;
    step(); idle(); rs = 3; rt = 4; #1;
    n_cmp++;
    if (rs_data !== 32'h1234) begin n_bad++; $display("FAIL pre_reset: got %h want 1234", rs_data); end
    n_cmp++;
    if (rt_busy !== SB || pend_any !== SB) begin
      n_bad++; $display("FAIL pre_reset_busy: rt_busy=%b pend_any=%b want %b", rt_busy, pend_any, SB);
    end
    #1 rst = 1; #1;
    n_cmp++;
    if (rs_data !== 32'h0 || rt_busy !== 1'b0 || pend_any !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: rs_data=%h rt_busy=%b pend_any=%b want 0", rs_data, rt_busy, pend_any);
    end
    // Bypass still visible during reset, but nothing is stored.
    wb_we = 1; wb_rd = 3; wb_data = 32'hAA; pend_set = 1; pend_rd = 4; #1;
    n_cmp++;
    if (rs_data !== 32'hAA) begin n_bad++; $display("FAIL reset_bypass: got %h want aa", rs_data); end
    step(); idle(); #1;
    n_cmp++;
    if (rs_data !== 32'h0 || rt_busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_discard: rs_data=%h rt_busy=%b want 0/0", rs_data, rt_busy);
    end
    rst = 0;
    wb_we = 1; wb_rd = 3; wb_data = 32'hBB;
    step(); idle(); #1;
    n_cmp++;
    if (rs_data !== 32'hBB) begin n_bad++; $display("FAIL post_reset_write: got %h want bb", rs_data); end
  endtask

  initial begin
    test_reset();
    test_wb_bypass();
    test_ld_bypass();
    test_collision();
    test_scoreboard();
    test_reg_zero();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uparc_reg_file_mp.md
UPARC_REG_FILE_MP -- requirements
Module: uparc_reg_file_mp

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, register width in bits.
REQ-002 SHALL provide parameter ADDR_WIDTH, default 5, register index width; depth = 2**ADDR_WIDTH.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide ports rs, rt  input  ADDR_WIDTH  read port A/B register index.
REQ-006 SHALL provide ports rs_data, rt_data  output  DATA_WIDTH  read port A/B data, combinational.
REQ-007 SHALL provide ports rs_busy, rt_busy  output  1  read port A/B register has a load outstanding.
REQ-008 SHALL provide ports wb_we  input  1, wb_rd  input  ADDR_WIDTH, wb_data  input  DATA_WIDTH: pipeline writeback port.
REQ-009 SHALL provide ports ld_we  input  1, ld_rd  input  ADDR_WIDTH, ld_data  input  DATA_WIDTH: late load-return write port.
REQ-010 SHALL provide ports pend_set  input  1, pend_rd  input  ADDR_WIDTH: mark register as awaiting load return.
REQ-011 SHALL provide port pend_any  output  1  at least one pending bit set.

Function
REQ-012 Register 0 SHALL read as zero, ignore all writes, never become pending.
REQ-013 Writes SHALL occur on rising clk edge when the port's write enable is 1; no write otherwise.
REQ-014 Read data SHALL bypass same-cycle writes: if wb_we and wb_rd==index, return wb_data; else if ld_we and ld_rd==index, return ld_data; else stored value.
REQ-015 Index 0 SHALL return zero regardless of bypass.
REQ-016 When wb_we and ld_we target the same nonzero register in one cycle, wb_data SHALL be stored (writeback port wins).
REQ-017 Pending bit of pend_rd SHALL be set at the clock edge when pend_set=1 and pend_rd!=0.
REQ-018 Pending bit of ld_rd SHALL be cleared at the clock edge when ld_we=1.
REQ-019 When pend_set and ld_we target the same register in one cycle, the bit SHALL end set (new load wins).
REQ-020 A wb_we write SHALL NOT change pending state.
REQ-021 rs_busy SHALL equal pending[rs] AND NOT (ld_we AND ld_rd==rs); rt_busy likewise; both 0 for index 0.
REQ-022 pend_any SHALL be the OR of all registered pending bits (no bypass).
REQ-023 Read latency SHALL be zero cycles; write-to-read visibility via storage SHALL be one cycle.

Reset
REQ-024 Asserting rst SHALL immediately clear all registers to zero and all pending bits to zero, independent of clk.
REQ-025 During rst, rs_busy, rt_busy, pend_any SHALL be 0; rs_data/rt_data SHALL reflect zero storage plus bypass.
REQ-026 Writes and pend_set presented while rst=1 SHALL be discarded; first update occurs on first rising edge after deassertion.

Configuration
REQ-027 Macro UPARC_RF_SCOREBOARD_EN SHALL control the pending-load scoreboard.
REQ-028 With UPARC_RF_SCOREBOARD_EN defined: REQ-017..REQ-022 apply.
REQ-029 Without it: no pending storage; rs_busy, rt_busy, pend_any tied 0; pend_set/pend_rd ignored; data paths unchanged.

Verification
REQ-030 Reset, then read all indices -> all rs_data/rt_data = 0, busy outputs = 0, pend_any = 0.
REQ-031 wb_we=1 wb_rd=5 wb_data=0xDEADBEEF, rs=5 same cycle -> rs_data=0xDEADBEEF that cycle and after edge with wb_we=0.
REQ-032 wb_we=1 and ld_we=1 both rd=7, wb_data=0x11, ld_data=0x22 -> rs=7 reads 0x11 same cycle and 0x11 next cycle.
REQ-033 pend_set rd=9; next cycle rt=9 -> rt_busy=1, pend_any=1; ld_we rd=9 ld_data=0x55 -> rt_busy=0, rt_data=0x55 same cycle; next cycle pend_any=0.
REQ-034 Writes and pend_set to register 0 with data 0xFFFFFFFF -> rs=0 reads 0, rs_busy=0, pend_any=0.
REQ-035 Write 0x1234 to r3, assert rst mid-cycle -> r3 reads 0 without clock edge; with scoreboard disabled, pend_set rd=4 -> rs_busy stays 0.
